hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. Resolves operand sources for any number of register read ports, generalising rs/rt and store-data forwarding into identical per-port logic. Forwarding selects are decided in ID and registered, so they arrive aligned with the instruction entering EX. Also generates load-use stalls and bubbles, and keeps a saturating stall counter.

## Interface
- AW, 4: register address width; address 0 is hardwired zero.
- NRP, 3: number of read ports (port 0 = rs, 1 = rt, 2 = store data rd).
- CNT_W, 16: stall counter width.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_raddr  in  NRP*AW  ID-stage read addresses; port i at [i*AW +: AW]
- id_rvalid  in  NRP  port i actually reads a register
- idex_waddr / exmem_waddr / memwb_waddr  in  AW each  destination register per stage
- idex_wen / exmem_wen / memwb_wen  in  1 each  stage writes RF
- idex_mem2reg / exmem_mem2reg  in  1 each  stage instruction is a load
- flush  in  1  branch/jump squash of ID
- fwd_sel  out  NRP*2  EX operand source per port (registered)
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- fwd_sel encoding: 00 register-file value; 01 MEM/WB ALU result; 10 EX/MEM ALU result; 11 MEM/WB load data.
- Per port i, a match against stage S requires all of: id_rvalid[i], S_wen, S_waddr != 0, and S_waddr == raddr[i].
- Next-cycle select for port i:
  - IDEX match and not load → 10.
  - Otherwise, EXMEM match → 01 if not load, 11 if load.
  - Otherwise → 00.
  - IDEX takes priority over EXMEM (youngest writer wins).
- Load-use hazard: any port matches IDEX with idex_mem2reg=1.
- Register update each cycle:
  - If stall or flush is asserted, fwd_sel <= 0 (EX receives a bubble).
  - Otherwise fwd_sel <= the computed selects.
- stall = bubble = hazard & ~flush (combinational, same cycle). flush beats stall.
- stall_count increments on every stall cycle and saturates at all-ones.
- MEM/WB matches are not forwarded from ID. The register file is write-before-read, so a WB write is visible to ID in the same cycle.

## Timing
- fwd_sel latency: one cycle, decided in ID at cycle t and valid during EX at t+1.
- Reset values: fwd_sel=0, stall_count=0. stall and bubble follow their inputs; they are 0 when no load is in IDEX.
- Load-use sequence (FWD_LOAD_EN defined):
  - t0: load in IDEX, dependent instruction in ID → stall=1.
  - t1: load in EXMEM → EXMEM-load match, no stall; fwd_sel=11 at t2.
- A stall lasts exactly the cycles the condition holds; it is never latched.
- rst asserted mid-stall: outputs return to reset values next edge; stall_count clears.
- Simultaneous flush and hazard: no stall; fwd_sel <= 0.
- All ports are evaluated independently. Two ports may show different codes in the same cycle.

## Configuration
- HAZARD_FWD_LOAD_EN defined: load data is forwarded from MEM/WB (code 11); load-use costs 1 stall cycle.
- HAZARD_FWD_LOAD_EN undefined:
  - Code 11 is never produced.
  - An EXMEM match with exmem_mem2reg=1 is also a hazard, so load-use costs 2 stall cycles.
  - The value then comes from the write-before-read register file (sel 00).

## Structure
- Package hazard_pkg holds:
  - FWD_RF, FWD_MEMWB, FWD_EXMEM, FWD_MEMWB_LD as 2-bit constants.
  - the fwd_sel_t typedef.
  - the default CNT_W.
- One sub-module, fwd_match: per-port comparator (addr, valid, waddr, wen → match), instantiated NRP×2 times via generate.

## Test plan
- ALU chain: IDEX writes r3 (non-load), ID port0=r3 → next cycle fwd_sel[1:0]=10; stall=0.
- Double writer: IDEX and EXMEM both write r5, port1=r5 → fwd_sel[3:2]=10, not 01.
- Load-use with macro: load r2 in IDEX, port0=r2 → stall=bubble=1 for 1 cycle, then fwd_sel[1:0]=11, stall_count=1.
- Load-use without macro: same stimulus → stall for 2 consecutive cycles, then fwd_sel[1:0]=00, stall_count=2.
- r0 and invalid ports: IDEX writes r0 with port0=r0, and port2 matching with id_rvalid[2]=0 → all selects 00, no stall.
- Flush/reset/saturation: flush during load hazard → stall=0, fwd_sel=0. Force CNT_W=2 with 5 stall cycles → stall_count=3. rst mid-stall → stall_count=0 next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared forwarding codes, select type and defaults for the hazard/forwarding unit.
// Build option: HAZARD_FWD_LOAD_EN enables load-data forwarding from MEM/WB.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF       = 2'b00;
  localparam fwd_sel_t FWD_MEMWB    = 2'b01;
  localparam fwd_sel_t FWD_EXMEM    = 2'b10;
  localparam fwd_sel_t FWD_MEMWB_LD = 2'b11;

  localparam int HZ_CNT_W = 16;

  // Youngest writer wins; an EX/MEM load only forwards when ld_en is set.
  function automatic fwd_sel_t fwd_pick(
    input logic idex_m,
    input logic idex_ld,
    input logic exmem_m,
    input logic exmem_ld,
    input logic ld_en
  );
    fwd_sel_t s;
    s = FWD_RF;
    if (idex_m && !idex_ld)
      s = FWD_EXMEM;
    else if (exmem_m && !exmem_ld)
      s = FWD_MEMWB;
    else if (exmem_m && exmem_ld && ld_en)
      s = FWD_MEMWB_LD;
    return s;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Single read-port vs writer-stage comparator.
// Register 0 never matches since it is hardwired to zero.
module fwd_match #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] addr,
  input  logic          valid,
  input  logic [AW-1:0] waddr,
  input  logic          wen,
  output logic          match
);

  assign match = valid & wen &
                 (waddr != '0) &
                 (waddr == addr);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding select and load-use stall generation for NRP read ports.
// Build option: HAZARD_FWD_LOAD_EN (forward load data, 1-cycle load-use).
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int AW    = 4,
  parameter int NRP   = 3,
  parameter int CNT_W = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NRP*AW-1:0] id_raddr,
  input  logic [NRP-1:0]   id_rvalid,
  input  logic [AW-1:0]    idex_waddr,
  input  logic [AW-1:0]    exmem_waddr,
  input  logic [AW-1:0]    memwb_waddr,
  input  logic             idex_wen,
  input  logic             exmem_wen,
  input  logic             memwb_wen,
  input  logic             idex_mem2reg,
  input  logic             exmem_mem2reg,
  input  logic             flush,
  output logic [NRP*2-1:0] fwd_sel,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);

`ifdef HAZARD_FWD_LOAD_EN
  localparam logic LD_EN = 1'b1;
`else
  localparam logic LD_EN = 1'b0;
`endif

  logic [NRP-1:0]   m_idex;
  logic [NRP-1:0]   m_exmem;
  logic [NRP*2-1:0] sel_nxt;
  logic             hazard;

  // WB writes land in the RF before ID reads, so MEM/WB is never compared.
  wire unused_memwb = &{1'b0, memwb_waddr, memwb_wen};

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_port
      fwd_match #(.AW(AW)) u_idex (
        .addr  (id_raddr[gi*AW +: AW]),
        .valid (id_rvalid[gi]),
        .waddr (idex_waddr),
        .wen   (idex_wen),
        .match (m_idex[gi])
      );
      fwd_match #(.AW(AW)) u_exmem (
        .addr  (id_raddr[gi*AW +: AW]),
        .valid (id_rvalid[gi]),
        .waddr (exmem_waddr),
        .wen   (exmem_wen),
        .match (m_exmem[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_nxt = '0;
    hazard  = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      if (m_idex[i] && idex_mem2reg)
        hazard = 1'b1;
      if (!LD_EN && m_exmem[i] && exmem_mem2reg)
        hazard = 1'b1;
      sel_nxt[i*2 +: 2] = fwd_pick(m_idex[i], idex_mem2reg,
                                   m_exmem[i], exmem_mem2reg,
                                   LD_EN);
    end
  end

  assign stall  = hazard & ~flush;
  assign bubble = hazard & ~flush;

  always_ff @(posedge clk) begin
    if (rst)
      fwd_sel <= '0;
    else if (stall || flush)
      fwd_sel <= '0;
    else
      fwd_sel <= sel_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed vectors, negedge monitor.
// Expectations cover both HAZARD_FWD_LOAD_EN builds.
module tb_hazard_fwd_unit;

`ifdef HAZARD_FWD_LOAD_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif
  localparam int B = LD ? 1 : 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] id_raddr = '0;
  logic [2:0]  id_rvalid = '0;
  logic [3:0]  idex_waddr = '0;
  logic [3:0]  exmem_waddr = '0;
  logic [3:0]  memwb_waddr = '0;
  logic        idex_wen = 1'b0;
  logic        exmem_wen = 1'b0;
  logic        memwb_wen = 1'b0;
  logic        idex_mem2reg = 1'b0;
  logic        exmem_mem2reg = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic        bubble;
  logic [15:0] stall_count;
  logic [5:0]  s_fwd_sel;
  logic        s_stall;
  logic        s_bubble;
  logic [1:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk           (clk),
    .rst           (rst),
    .id_raddr      (id_raddr),
    .id_rvalid     (id_rvalid),
    .idex_waddr    (idex_waddr),
    .exmem_waddr   (exmem_waddr),
    .memwb_waddr   (memwb_waddr),
    .idex_wen      (idex_wen),
    .exmem_wen     (exmem_wen),
    .memwb_wen     (memwb_wen),
    .idex_mem2reg  (idex_mem2reg),
    .exmem_mem2reg (exmem_mem2reg),
    .flush         (flush),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .bubble        (bubble),
    .stall_count   (stall_count)
  );

  hazard_fwd_unit #(.CNT_W(2)) u_sat (
    .clk           (clk),
    .rst           (rst),
    .id_raddr      (id_raddr),
    .id_rvalid     (id_rvalid),
    .idex_waddr    (idex_waddr),
    .exmem_waddr   (exmem_waddr),
    .memwb_waddr   (memwb_waddr),
    .idex_wen      (idex_wen),
    .exmem_wen     (exmem_wen),
    .memwb_wen     (memwb_wen),
    .idex_mem2reg  (idex_mem2reg),
    .exmem_mem2reg (exmem_mem2reg),
    .flush         (flush),
    .fwd_sel       (s_fwd_sel),
    .stall         (s_stall),
    .bubble        (s_bubble),
    .stall_count   (s_count)
  );

  typedef struct {
    string       nm;
    logic        rst;
    logic        flush;
    logic [11:0] ra;
    logic [2:0]  rv;
    logic [3:0]  iw;
    logic        iwe;
    logic        ild;
    logic [3:0]  ew;
    logic        ewe;
    logic        eld;
    logic [5:0]  efwd;
    logic        estall;
    logic [15:0] ecnt;
    logic [1:0]  esat;
  } vec_t;

  vec_t q[$];

  function automatic logic [1:0] sat3(input int x);
    return (x > 3) ? 2'd3 : 2'(x);
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      vec_t e;
      e = q.pop_front();
      chk(e.nm, "fwd_sel", 16'(fwd_sel), 16'(e.efwd));
      chk(e.nm, "stall", 16'(stall), 16'(e.estall));
      chk(e.nm, "bubble", 16'(bubble), 16'(e.estall));
      chk(e.nm, "stall_count", stall_count, e.ecnt);
      chk(e.nm, "sat_count", 16'(s_count), 16'(e.esat));
    end
  end

  task automatic step(input string nm, input logic r, input logic fl,
                      input logic [11:0] ra, input logic [2:0] rv,
                      input logic [3:0] iw, input logic iwe,
                      input logic ild, input logic [3:0] ew,
                      input logic ewe, input logic eld,
                      input logic [5:0] efwd, input logic est,
                      input int ecnt);
    vec_t v;
    @(posedge clk);
    #1;
    rst = r;
    flush = fl;
    id_raddr = ra;
    id_rvalid = rv;
    idex_waddr = iw;
    idex_wen = iwe;
    idex_mem2reg = ild;
    exmem_waddr = ew;
    exmem_wen = ewe;
    exmem_mem2reg = eld;
    v.nm = nm; v.rst = r; v.flush = fl; v.ra = ra; v.rv = rv;
    v.iw = iw; v.iwe = iwe; v.ild = ild;
    v.ew = ew; v.ewe = ewe; v.eld = eld;
    v.efwd = efwd; v.estall = est;
    v.ecnt = 16'(ecnt);
    v.esat = sat3(ecnt);
    q.push_back(v);
  endtask

  function automatic logic [11:0] ra3(input logic [3:0] a2,
                                      input logic [3:0] a1,
                                      input logic [3:0] a0);
    return {a2, a1, a0};
  endfunction

  initial begin
    //   name    rst fl  raddr           rv    iw iwe ild ew ewe eld  efwd   st cnt
    step("reset", 1, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    step("alu",   0, 0, ra3(0,0,3), 3'b001, 3, 1, 0, 0, 0, 0, 6'b000000, 0, 0);
    step("dbl",   0, 0, ra3(0,5,0), 3'b010, 5, 1, 0, 5, 1, 0, 6'b000010, 0, 0);
    step("idle1", 0, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
    step("indep", 0, 0, ra3(7,0,6), 3'b101, 6, 1, 0, 7, 1, 0, 6'b000000, 0, 0);
    step("r0inv", 0, 0, ra3(9,4,0), 3'b011, 0, 1, 0, 9, 1, 0, 6'b010010, 0, 0);
    step("idle2", 0, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    step("ld_t0", 0, 0, ra3(0,0,2), 3'b001, 2, 1, 1, 0, 0, 0, 6'b000000, 1, 0);
    step("ld_t1", 0, 0, ra3(0,0,2), 3'b001, 0, 0, 0, 2, 1, 1, 6'b000000, !LD, 1);
    step("ld_t2", 0, 0, ra3(0,0,2), 3'b001, 0, 0, 0, 0, 0, 0,
         LD ? 6'b000011 : 6'b000000, 0, B);
    step("ld_t3", 0, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, 0, B);
    step("flhz",  0, 1, ra3(0,0,2), 3'b001, 2, 1, 1, 0, 0, 0, 6'b000000, 0, B);
    step("alu2",  0, 0, ra3(0,0,3), 3'b001, 3, 1, 0, 0, 0, 0, 6'b000000, 0, B);
    step("flalu", 0, 1, ra3(0,0,3), 3'b001, 3, 1, 0, 0, 0, 0, 6'b000010, 0, B);
    step("flchk", 0, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, 0, B);
    for (int k = 0; k < 5; k++)
      step("sat", 0, 0, ra3(0,0,2), 3'b001, 2, 1, 1, 0, 0, 0, 6'b000000, 1, B + k);
    step("rstmid", 1, 0, ra3(0,0,2), 3'b001, 2, 1, 1, 0, 0, 0, 6'b000000, 1, B + 5);
    step("postrst", 0, 0, ra3(0,0,0), 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    for (int k = 0; k < 4 && q.size() > 0; k++)
      @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
